// File: rtl/i2s_tdm_master_tx.sv
// I2S / left-justified TDM transmitter: AXI4-Stream sample FIFO feeding a
// self-clocked serialiser that derives bclk and lrclk from S_AXIS_ACLK.
module i2s_tdm_master_tx #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH         = 24,
    parameter int SLOT_WIDTH           = 32,
    parameter int NUM_CHANNELS         = 2,
    parameter int BCLK_DIV             = 4,
    parameter int FIFO_DEPTH           = 8
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESET,
    input  logic                            enable,
    input  logic                            mode_lj,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic                            bclk,
    output logic                            lrclk,
    output logic                            sdata,
    output logic [15:0]                     underrun_count,
    output logic                            align_err
);
    localparam int DW  = $clog2(BCLK_DIV);
    localparam int BW  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int SLW = $clog2(NUM_CHANNELS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [DW-1:0]  DIV_LAST  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF  = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(SLOT_WIDTH - 1);
    localparam logic [SLW-1:0] SLOT_LAST = SLW'(NUM_CHANNELS - 1);
    localparam logic [SLW-1:0] SLOT_HALF = SLW'(NUM_CHANNELS / 2);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  CNT_FRAME = CW'(NUM_CHANNELS);

    typedef enum logic {ST_IDLE = 1'b0, ST_FRAME = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           div_q, div_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [SLW-1:0]          slot_q, slot_d;
    logic                    live_q, live_d;
    logic                    mode_q, mode_d;
    logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
    logic                    delay_q, delay_d;
    logic                    bclk_q, bclk_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic [15:0]             underrun_q, underrun_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [SLW-1:0]          wr_idx_q, wr_idx_d;
    logic                    align_err_q, align_err_d;
    logic                    rdy_q, rdy_d;

    logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic [SAMPLE_WIDTH-1:0] word;
    logic                    push, pop, bit_end, frame_end, frame_start;
    logic                    emit, slot_start, stream_bit;
    logic                    unused_tdata;

    assign sample_in    = S_AXIS_TDATA[C_S_AXIS_TDATA_WIDTH-1 -: SAMPLE_WIDTH];
    assign unused_tdata = ^S_AXIS_TDATA;

    // Beat transfers on a rising edge where TVALID && TREADY; TREADY comes
    // only from registered state so it never depends on TVALID.
    assign S_AXIS_TREADY  = rdy_q && (count_q != CNT_FULL);
    assign bclk           = bclk_q;
    assign lrclk          = lrclk_q;
    assign sdata          = sdata_q;
    assign underrun_count = underrun_q;
    assign align_err      = align_err_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        live_d      = live_q;
        mode_d      = mode_q;
        shreg_d     = shreg_q;
        delay_d     = delay_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        underrun_d  = underrun_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_idx_d    = wr_idx_q;
        align_err_d = align_err_q;
        rdy_d       = 1'b1;
        word        = '0;
        stream_bit  = 1'b0;
        pop         = 1'b0;
        emit        = 1'b0;
        slot_start  = 1'b0;
        frame_start = 1'b0;
        push        = S_AXIS_TVALID && S_AXIS_TREADY;
        bit_end     = (state_q == ST_FRAME) && (div_q == DIV_LAST);
        frame_end   = bit_end && (bit_q == BIT_LAST) && (slot_q == SLOT_LAST);

        if (state_q == ST_FRAME) begin
            div_d = bit_end ? '0 : div_q + DW'(1);
        end

        if (state_q == ST_IDLE) begin
            frame_start = enable;
        end else if (frame_end) begin
            if (enable) begin
                frame_start = 1'b1;
            end else begin
                state_d = ST_IDLE;
                div_d   = '0;
                bit_d   = '0;
                slot_d  = '0;
                delay_d = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
            end
        end else if (bit_end) begin
            emit = 1'b1;
            if (bit_q == BIT_LAST) begin
                bit_d      = '0;
                slot_d     = slot_q + SLW'(1);
                slot_start = 1'b1;
            end else begin
                bit_d = bit_q + BW'(1);
            end
        end

        if (frame_start) begin
            state_d    = ST_FRAME;
            div_d      = '0;
            bit_d      = '0;
            slot_d     = '0;
            mode_d     = mode_lj;
            live_d     = (count_q >= CNT_FRAME);
            emit       = 1'b1;
            slot_start = 1'b1;
            if (!live_d && underrun_q != 16'hFFFF) begin
                underrun_d = underrun_q + 16'd1;
            end
        end

        // The shift register fills with zeros, which produces the slot padding.
        if (slot_start) begin
            pop        = live_d;
            word       = live_d ? mem_q[rd_ptr_q] : '0;
            stream_bit = word[SAMPLE_WIDTH-1];
            shreg_d    = word << 1;
        end else begin
            stream_bit = shreg_q[SAMPLE_WIDTH-1];
            if (emit) begin
                shreg_d = shreg_q << 1;
            end
        end

        if (emit) begin
            lrclk_d = (slot_d >= SLOT_HALF);
            sdata_d = mode_d ? stream_bit : delay_q;
            delay_d = stream_bit;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (S_AXIS_TLAST) begin
                if (wr_idx_q != SLOT_LAST) begin
                    align_err_d = 1'b1;
                end
                wr_idx_d = '0;
            end else if (wr_idx_q == SLOT_LAST) begin
                align_err_d = 1'b1;
                wr_idx_d    = '0;
            end else begin
                wr_idx_d = wr_idx_q + SLW'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase

        bclk_d = (state_d == ST_FRAME) && (div_d >= DIV_HALF);
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            slot_q      <= '0;
            live_q      <= 1'b0;
            mode_q      <= 1'b0;
            shreg_q     <= '0;
            delay_q     <= 1'b0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_idx_q    <= '0;
            align_err_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            live_q      <= live_d;
            mode_q      <= mode_d;
            shreg_q     <= shreg_d;
            delay_q     <= delay_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_idx_q    <= wr_idx_d;
            align_err_q <= align_err_d;
            rdy_q       <= rdy_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end
endmodule

// File: tb/tb_i2s_tdm_master_tx.sv
// Bench for i2s_tdm_master_tx: a frame-level reference model fills an expected
// bit queue; a monitor compares each bclk rising edge and the status outputs.
module tb_i2s_tdm_master_tx;
    localparam int TDW       = 32;
    localparam int SW        = 24;
    localparam int SLOT      = 32;
    localparam int NCH       = 2;
    localparam int DIV       = 4;
    localparam int DEPTH     = 8;
    localparam int SLOT_LEN  = SLOT * DIV;
    localparam int FRAME_LEN = NCH * SLOT_LEN;

    logic           clk     = 1'b0;
    logic           rst     = 1'b1;
    logic           enable  = 1'b0;
    logic           mode_lj = 1'b0;
    logic [TDW-1:0] tdata   = '0;
    logic           tvalid  = 1'b0;
    logic           tlast   = 1'b0;
    logic           tready, bclk, lrclk, sdata, aerr;
    logic [15:0]    ucnt;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    i2s_tdm_master_tx #(
        .C_S_AXIS_TDATA_WIDTH(TDW), .SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT),
        .NUM_CHANNELS(NCH), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .enable(enable), .mode_lj(mode_lj),
        .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast),
        .S_AXIS_TREADY(tready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .underrun_count(ucnt), .align_err(aerr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Reference model state.
    logic [SW-1:0] m_fifo[$];
    logic [1:0]    exp_q[$];
    bit            m_rdy, m_run, m_mode, m_prev, m_live, m_aerr, m_acc;
    int            m_t, m_idx, m_edges;
    int unsigned   m_ucnt;

    always @(posedge clk) begin : model
        bit            acc, start, lj, outb;
        logic [SW-1:0] w;
        m_edges++;
        if (rst) begin
            m_rdy = 0; m_run = 0; m_prev = 0; m_live = 0; m_aerr = 0; m_acc = 0;
            m_t = 0; m_idx = 0; m_ucnt = 0;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            acc   = tvalid && m_rdy && (m_fifo.size() < DEPTH);
            start = 0;
            if (m_run) begin
                m_t++;
                if (m_t == FRAME_LEN) begin
                    if (enable) start = 1;
                    else begin m_run = 0; m_prev = 0; m_t = 0; end
                end else if (m_live && (m_t % SLOT_LEN) == 0) begin
                    void'(m_fifo.pop_front());
                end
            end else if (enable) begin
                start = 1;
            end
            if (start) begin
                m_run  = 1;
                m_t    = 0;
                m_mode = mode_lj;
                m_live = (m_fifo.size() >= NCH);
                if (!m_live && m_ucnt < 65535) m_ucnt++;
                for (int s = 0; s < NCH; s++) begin
                    w = m_live ? m_fifo[s] : '0;
                    for (int b = 0; b < SLOT; b++) begin
                        lj     = (b < SW) ? w[SW-1-b] : 1'b0;
                        outb   = m_mode ? lj : m_prev;
                        m_prev = lj;
                        exp_q.push_back({(s >= NCH / 2) ? 1'b1 : 1'b0, outb});
                    end
                end
                if (m_live) void'(m_fifo.pop_front());
            end
            if (acc) begin
                m_fifo.push_back(tdata[TDW-1 -: SW]);
                if (tlast) begin
                    if (m_idx != NCH - 1) m_aerr = 1;
                    m_idx = 0;
                end else if (m_idx == NCH - 1) begin
                    m_aerr = 1;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
            m_acc = acc;
            m_rdy = 1;
        end
    end

    // Monitor: status every cycle, serial data on each bclk rising edge.
    logic prev_bclk = 1'b0;
    always @(negedge clk) begin : monitor
        logic [1:0] e;
        if (m_edges > 0) begin
            check("bclk", bclk, m_run && ((m_t % DIV) >= DIV / 2));
            check("lrclk", lrclk, m_run && ((m_t / SLOT_LEN) >= NCH / 2));
            if (!m_run) check("sdata_idle", sdata, 0);
            check("tready", tready, m_rdy && (m_fifo.size() < DEPTH));
            check("underrun_count", ucnt, 16'(m_ucnt));
            check("align_err", aerr, m_aerr);
            if (bclk === 1'b1 && prev_bclk !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL stream_extra at %0t: got bclk edge, expected none", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_lrclk", lrclk, e[1]);
                    check("stream_sdata", sdata, e[0]);
                end
            end
        end
        prev_bclk = bclk;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [TDW-1:0] d, input logic l);
        int guard;
        guard  = 0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (!m_acc && guard < 5000);
        if (!m_acc) begin
            checks++;
            $display("FAIL push_timeout at %0t: got no accept, expected accept", $time);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_run && guard < 4 * FRAME_LEN) begin
            @(posedge clk); #1;
            guard++;
        end
        if (m_run) begin
            checks++;
            $display("FAIL idle_timeout at %0t: got running, expected idle", $time);
        end
        wait_cycles(20);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
        $fatal(1, "watchdog");
    end

    int k, g;
    initial begin
        // Reset state.
        wait_cycles(10);
        check("reset_tready", tready, 0);
        check("reset_bclk", bclk, 0);
        rst = 1'b0;
        wait_cycles(1);
        check("tready_after_reset", tready, 1);
        check("ucnt_after_reset", ucnt, 0);

        // Left-justified stereo, single frame.
        push(32'hF0F0F0F0, 1'b0);
        push(32'h0A0A0A0A, 1'b1);
        mode_lj = 1'b1; enable = 1'b1; wait_cycles(1); enable = 1'b0;
        wait_idle();

        // I2S delay and padding, single frame.
        push(32'hF0F0F0F0, 1'b0);
        push(32'h0A0A0A0A, 1'b1);
        mode_lj = 1'b0; enable = 1'b1; wait_cycles(1); enable = 1'b0;
        wait_idle();

        // Underrun frame, then data pushed mid-frame goes out in the next one.
        enable = 1'b1;
        wait_cycles(100);
        push(32'h0B0B0B0B, 1'b0);
        push(32'h0C0C0C0C, 1'b1);
        wait_cycles(FRAME_LEN);
        enable = 1'b0;
        wait_idle();
        check("ucnt_after_underrun", ucnt, 1);

        // Backpressure: 8 beats fill the FIFO, the 9th waits for the first pop.
        mode_lj = 1'b1;
        fork
            begin
                for (int i = 0; i < 9; i++) push($urandom, (i % 2) == 1);
            end
            begin
                g = 0;
                while (m_fifo.size() < DEPTH && g < 200) begin @(posedge clk); #1; g++; end
                wait_cycles(20);
                check("tready_full", tready, 0);
                enable = 1'b1;
            end
        join
        wait_cycles(FRAME_LEN * 3 + 10);
        enable = 1'b0;
        wait_idle();

        // Misaligned TLAST, then a frame stopped early still completes.
        push($urandom, 1'b0);
        push($urandom, 1'b0);
        push($urandom, 1'b1);
        check("align_err_set", aerr, 1);
        enable = 1'b1;
        wait_cycles(1 + 10 * DIV);
        enable = 1'b0;
        wait_idle();
        wait_cycles(50);

        // Randomised traffic, enable and format.
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) begin
                if (m_fifo.size() < DEPTH) push($urandom, 1'($urandom_range(0, 1)));
            end
            mode_lj = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 3) != 0);
            wait_cycles($urandom_range(1, 300));
        end
        enable = 1'b0;
        wait_idle();

        // Reset mid-frame discards FIFO contents.
        push(32'h12345678, 1'b0);
        push(32'h9ABCDEF0, 1'b1);
        mode_lj = 1'b0; enable = 1'b1;
        wait_cycles(150);
        rst = 1'b1; enable = 1'b0;
        wait_cycles(3);
        check("midreset_bclk", bclk, 0);
        check("midreset_ucnt", ucnt, 0);
        rst = 1'b0;
        wait_cycles(2);
        enable = 1'b1; wait_cycles(1); enable = 1'b0;
        wait_idle();
        check("ucnt_after_midreset", ucnt, 1);
        check("align_err_after_midreset", aerr, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
